// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg: shared checker state encoding and default widths
package counter_chk_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int ERR_W_DEF = 16;
  typedef enum logic [1:0] {UNSYNC, CHECK, FAIL} state_t;
endpackage

// File: rtl/counter_ref_model.sv
// counter_ref_model: next expected value of the observed up/down/load counter
module counter_ref_model
  import counter_chk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] exp,
  input  logic             dut_reset,
  input  logic             load,
  input  logic             mode,
  input  logic [CNT_W-1:0] data,
  output logic [CNT_W-1:0] next_exp
);
  always_comb
    next_exp = dut_reset ? '0 : load ? data : mode ? exp + CNT_W'(1) : exp - CNT_W'(1);
endmodule

// File: rtl/counter_checker.sv
// counter_checker: tracks an up/down/load counter and scores its output one cycle late
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dut_reset,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] data,
  input  logic [CNT_W-1:0] data_out,
  input  logic             enable,
  input  logic             clear,
  input  logic             stop_on_err,
  output logic             synced,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      chk_cnt,
  output logic [CNT_W-1:0] first_exp,
  output logic [CNT_W-1:0] first_act,
  output logic             failed
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] exp_q, exp_nxt;
  logic cmp, mis;
  counter_ref_model #(.CNT_W(CNT_W)) u_model (
    .exp(exp_q), .dut_reset(dut_reset), .load(load), .mode(mode), .data(data), .next_exp(exp_nxt)
  );
  always_comb begin
    cmp = (state == CHECK) && enable;
    mis = cmp && (data_out != exp_q);
    state_nxt = clear ? UNSYNC :
                (state == UNSYNC && (dut_reset || load)) ? CHECK :
                (mis && stop_on_err) ? FAIL : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= UNSYNC;
    else state <= state_nxt;
  // the model keeps following the counter regardless of clear or checker state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      exp_q <= '0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
      chk_cnt <= '0;
      first_exp <= '0;
      first_act <= '0;
    end else begin
      exp_q <= exp_nxt;
      if (clear) begin
        err_pulse <= 1'b0;
        err_cnt <= '0;
        chk_cnt <= '0;
        first_exp <= '0;
        first_act <= '0;
      end else begin
        err_pulse <= mis;
        if (cmp) chk_cnt <= chk_cnt + {31'b0, ~&chk_cnt};
        if (mis) err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, ~&err_cnt};
        if (mis && err_cnt == '0) begin
          first_exp <= exp_q;
          first_act <= data_out;
        end
      end
    end
  assign synced = state != UNSYNC;
  assign failed = state == FAIL;
endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter: CNT_W, default 32, observed counter data width.
REQ-002 Parameter: ERR_W, default 16, error counter width.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  checker reset, asynchronous, active-high.
REQ-005 dut_reset  input  1  observed counter reset request, sampled synchronously.
REQ-006 mode  input  1  observed direction; 1 = up, 0 = down.
REQ-007 load  input  1  observed synchronous load strobe.
REQ-008 data  input  CNT_W  observed load value.
REQ-009 data_out  input  CNT_W  observed counter output.
REQ-010 enable  input  1  1 = checking active; 0 = model tracks, compare suppressed.
REQ-011 clear  input  1  synchronous clear of statistics and return to UNSYNC.
REQ-012 stop_on_err  input  1  1 = enter FAIL on first mismatch.
REQ-013 synced  output  1  high in CHECK or FAIL.
REQ-014 err_pulse  output  1  one-cycle pulse per detected mismatch.
REQ-015 err_cnt  output  ERR_W  mismatch count, saturating.
REQ-016 chk_cnt  output  32  compare count, saturating at all-ones.
REQ-017 first_exp, first_act  output  CNT_W each  expected/actual value at first mismatch since clear.
REQ-018 failed  output  1  high in FAIL.

Function
REQ-019 Model update at each posedge, priority order: dut_reset -> exp = 0; else load -> exp = data; else mode=1 -> exp = exp+1; else exp = exp-1.
REQ-020 Model arithmetic modulo 2^CNT_W: all-ones +1 = 0; 0 -1 = all-ones.
REQ-021 Compare latency one cycle: data_out sampled at edge k+1 is compared with exp written at edge k.
REQ-022 FSM states: UNSYNC, CHECK, FAIL.
REQ-023 UNSYNC -> CHECK at an edge where dut_reset or load is sampled high; no compare in UNSYNC or on that transition edge.
REQ-024 In CHECK with enable=1: each edge is one compare; chk_cnt increments; on mismatch err_pulse=1 next cycle and err_cnt increments.
REQ-025 first_exp/first_act load only when err_cnt = 0 at the mismatch edge; otherwise held.
REQ-026 CHECK -> FAIL on mismatch when stop_on_err=1; FAIL holds all statistics and performs no compares; model keeps tracking.
REQ-027 With enable=0 the model tracks, no compare occurs, and counters hold.
REQ-028 clear=1: state -> UNSYNC; err_cnt, chk_cnt, first_exp, first_act, err_pulse -> 0; clear wins over a same-edge mismatch.
REQ-029 err_cnt and chk_cnt saturate at all-ones and never wrap.
REQ-030 dut_reset or load in CHECK/FAIL resynchronises the model only; state is unchanged.

Reset
REQ-031 reset asserted: state = UNSYNC; exp, err_cnt, chk_cnt, first_exp, first_act = 0; err_pulse, synced, failed = 0, immediately and asynchronously.
REQ-032 Reset asserted mid-compare discards the pending compare; no err_pulse after reset deasserts.

Structure
REQ-033 Package counter_chk_pkg holds the state enum (UNSYNC, CHECK, FAIL) and default CNT_W/ERR_W constants.
REQ-034 Next-value logic is one combinational sub-module, counter_ref_model (inputs: exp, dut_reset, load, mode, data; output: next exp).

Verification
REQ-035 Reset, dut_reset 1 cycle, then mode=1 for 5 cycles with data_out 0..5 correct -> err_cnt=0, chk_cnt=5, synced=1.
REQ-036 Load data=32'hFFFF_FFFE, mode=1, data_out FFFF_FFFE, FFFF_FFFF, 0, 1 -> zero errors (up wrap); mirror with load 1 and mode=0 down through 0 to FFFF_FFFF.
REQ-037 In CHECK with stop_on_err=0, force data_out=7 when exp=6 on two compares -> err_cnt=2, first_exp=6, first_act=7, two err_pulse.
REQ-038 stop_on_err=1, single mismatch -> failed=1 next cycle; further mismatches do not change err_cnt=1.
REQ-039 Same-edge dut_reset=1 and load=1 with data=32'h55 -> exp=0; data_out=0 next compare passes.
REQ-040 clear asserted on a mismatch edge -> err_cnt=0, err_pulse=0, state UNSYNC; async reset mid-run -> all outputs 0 within the same cycle.
